// File: rtl/imm_encoder.sv
// Purpose: encode a 32-bit constant into a rotated-imm8, imm12 or branch imm24 instruction field.
// Latency: 1 cycle to done for imm12/imm24/unsupported; rotIdx+2 for an imm8 hit, 17 for an imm8 miss.
// Backpressure: none; start is accepted only in IDLE, and is dropped (not queued) while busy.
module imm_encoder (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    input  logic [1:0]  immSrc,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        ok,
    output logic [23:0] instField
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ROT8  = 2'b00;
    localparam logic [1:0] MODE_IMM12 = 2'b01;
    localparam logic [1:0] MODE_BR24  = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] value_q, value_d;
    logic [3:0]  rot_q,   rot_d;
    logic        ok_q,    ok_d;
    logic [23:0] field_q, field_d;

    // Single-cycle modes are decided at accept time from the live inputs;
    // only the rotated-imm8 search needs the captured value afterwards.
    logic        dir_ok;
    logic [23:0] dir_field;

    logic [4:0]  rot_sh;
    logic [4:0]  rot_sh_n;
    logic [31:0] cand;
    logic        hit;

    // Result of the non-iterative modes, computed from the request inputs.
    always_comb begin
        dir_ok    = 1'b0;
        dir_field = 24'd0;
        case (immSrc)
            MODE_IMM12: begin
                dir_ok = (value[31:12] == 20'd0);
                if (dir_ok) begin
                    dir_field = {12'd0, value[11:0]};
                end
            end
            MODE_BR24: begin
                // Word-aligned byte offset that fits a signed 26-bit range.
                dir_ok = (value[1:0] == 2'b00) && (value[31:25] == {7{value[25]}});
                if (dir_ok) begin
                    dir_field = value[25:2];
                end
            end
            default: begin
                dir_ok    = 1'b0;
                dir_field = 24'd0;
            end
        endcase
    end

    // Current search candidate: captured value rotated left by 2*rotIdx.
    // The right shift uses the 5-bit two's complement of the amount, so a
    // zero rotation shifts right by 0 and ORs the value with itself.
    always_comb begin
        rot_sh   = {rot_q, 1'b0};
        rot_sh_n = 5'd0 - rot_sh;
        cand     = (value_q << rot_sh) | (value_q >> rot_sh_n);
        hit      = (cand[31:8] == 24'd0);
    end

    // Next-state and result update for the IDLE/SEARCH/DONE sequence.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        rot_d   = rot_q;
        ok_d    = ok_q;
        field_d = field_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    value_d = value;
                    if (immSrc == MODE_ROT8) begin
                        state_d = S_SEARCH;
                        rot_d   = 4'd0;
                        ok_d    = 1'b0;
                        field_d = 24'd0;
                    end else begin
                        state_d = S_DONE;
                        ok_d    = dir_ok;
                        field_d = dir_field;
                    end
                end
            end
            S_SEARCH: begin
                // Rotations are tried in ascending order, so the first hit is the lowest.
                if (hit) begin
                    state_d = S_DONE;
                    ok_d    = 1'b1;
                    field_d = {12'd0, rot_q, cand[7:0]};
                end else if (rot_q == 4'd15) begin
                    state_d = S_DONE;
                    ok_d    = 1'b0;
                    field_d = 24'd0;
                end else begin
                    rot_d = rot_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset clears everything without a done pulse.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            value_q <= 32'd0;
            rot_q   <= 4'd0;
            ok_q    <= 1'b0;
            field_q <= 24'd0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            rot_q   <= rot_d;
            ok_q    <= ok_d;
            field_q <= field_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign ok        = ok_q;
    assign instField = field_q;

endmodule
